// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and frame constants for the PS/2 receive path.
//   state_t        : receiver FSM states (IDLE, DPS, LOAD)
//   PS2_*          : frame length and bit positions within the 11-bit frame
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_START_BIT  = 0;
  localparam int PS2_PARITY_BIT = 9;
  localparam int PS2_STOP_BIT   = 10;

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: synchronises the raw PS/2 lines into clk and debounces the
// PS/2 clock, producing a one-cycle strobe on each filtered falling edge.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   ps2c, ps2d : raw PS/2 clock and data lines
//   ps2d_sync  : synchronised data line
//   fall_edge  : one-cycle pulse on a filtered ps2c falling edge
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_edge
);

  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic [FILTER_LEN-1:0]  filter_reg;
  logic                   f_ps2c_reg;
  logic                   f_ps2c_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync     <= '0;
      d_sync     <= '0;
      filter_reg <= '0;
      f_ps2c_reg <= 1'b0;
    end else begin
      c_sync     <= {c_sync[SYNC_STAGES-2:0], ps2c};
      d_sync     <= {d_sync[SYNC_STAGES-2:0], ps2d};
      filter_reg <= {c_sync[SYNC_STAGES-1], filter_reg[FILTER_LEN-1:1]};
      f_ps2c_reg <= f_ps2c_next;
    end
  end

  // The filtered clock only moves once the whole window agrees; mixed
  // windows (glitches shorter than FILTER_LEN) keep the previous level.
  always_comb begin
    f_ps2c_next = f_ps2c_reg;
    if (&filter_reg)
      f_ps2c_next = 1'b1;
    else if (~|filter_reg)
      f_ps2c_next = 1'b0;
  end

  assign fall_edge = f_ps2c_reg & ~f_ps2c_next;
  assign ps2d_sync = d_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_chk.sv
// ps2_rx_chk: PS/2 device-to-host receiver with input filtering, parity and
// framing checks, and a mid-frame inactivity watchdog.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   ps2d, ps2c   : raw PS/2 data and clock lines
//   rx_en        : receive enable, only looked at while idle
//   dout         : last completed data byte (held)
//   rx_done_tick : one-cycle pulse, frame complete; dout and flags valid
//   rx_idle      : high while the receiver is idle
//   parity_err   : last completed frame failed odd parity (held)
//   frame_err    : last completed frame had a bad start or stop bit (held)
//   timeout_tick : one-cycle pulse, stalled frame abandoned
//
// state | meaning
// IDLE  | waiting for a start-bit falling edge with rx_en high
// DPS   | shifting in data, parity and stop bits; watchdog running
// LOAD  | frame assembled; publish byte and error flags
module ps2_rx_chk
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       rx_idle,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  localparam int             WD_W   = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  logic ps2d_sync;
  logic fall_edge;

  ps2_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2d_sync(ps2d_sync),
    .fall_edge(fall_edge)
  );

  state_t                    state_reg, state_next;
  logic [PS2_FRAME_BITS-1:0] b_reg, b_next;
  logic [3:0]                n_reg, n_next;
  logic [WD_W-1:0]           wd_reg, wd_next;
  logic [7:0]                dout_reg, dout_next;
  logic                      par_reg, par_next;
  logic                      frm_reg, frm_next;
  logic                      done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      n_reg     <= '0;
      wd_reg    <= '0;
      dout_reg  <= '0;
      par_reg   <= 1'b0;
      frm_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      b_reg     <= b_next;
      n_reg     <= n_next;
      wd_reg    <= wd_next;
      dout_reg  <= dout_next;
      par_reg   <= par_next;
      frm_reg   <= frm_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    b_next       = b_reg;
    n_next       = n_reg;
    wd_next      = wd_reg;
    dout_next    = dout_reg;
    par_next     = par_reg;
    frm_next     = frm_reg;
    done_next    = 1'b0;
    timeout_tick = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_en && fall_edge) begin
          b_next     = {ps2d_sync, b_reg[PS2_FRAME_BITS-1:1]};
          n_next     = 4'd9;
          wd_next    = '0;
          state_next = DPS;
        end
      end
      DPS: begin
        // A falling edge takes priority over an expiring watchdog.
        if (fall_edge) begin
          b_next  = {ps2d_sync, b_reg[PS2_FRAME_BITS-1:1]};
          wd_next = '0;
          if (n_reg == 4'd0)
            state_next = LOAD;
          else
            n_next = n_reg - 4'd1;
        end else if (wd_reg == WD_MAX) begin
          // Suppressed during reset so a discarded frame never pulses.
          timeout_tick = ~reset;
          state_next   = IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      LOAD: begin
        done_next  = 1'b1;
        dout_next  = b_reg[8:1];
        par_next   = ~^b_reg[PS2_PARITY_BIT:1];
        frm_next   = b_reg[PS2_START_BIT] | ~b_reg[PS2_STOP_BIT];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dout         = dout_reg;
  assign parity_err   = par_reg;
  assign frame_err    = frm_reg;
  assign rx_done_tick = done_reg;
  assign rx_idle      = (state_reg == IDLE);

endmodule

// File: tb/tb_ps2_rx_chk.sv
// tb_ps2_rx_chk: directed bench for ps2_rx_chk (TIMEOUT_CYC=200).
module tb_ps2_rx_chk;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       rx_idle;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  int checks = 0;
  int errors = 0;

  ps2_rx_chk #(
    .SYNC_STAGES(2),
    .FILTER_LEN (8),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .rx_en       (rx_en),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .rx_idle     (rx_idle),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled on the falling clock edge.
  int         cyc = 0;
  int         fall_cyc = 0;
  int         fall_cnt = 0;
  int         done_cnt = 0;
  int         to_cnt = 0;
  int         busy_cnt = 0;
  int         done_lat = 0;
  int         to_lat = 0;
  logic [7:0] cap_dout = '0;
  logic       cap_par = 1'b0;
  logic       cap_frm = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_done_tick) begin
      done_cnt = done_cnt + 1;
      done_lat = cyc - fall_cyc;
      cap_dout = dout;
      cap_par  = parity_err;
      cap_frm  = frame_err;
    end
    if (timeout_tick) begin
      to_cnt = to_cnt + 1;
      to_lat = cyc - fall_cyc;
    end
    if (dut.fall_edge) begin
      fall_cyc = cyc;
      fall_cnt = fall_cnt + 1;
    end
    if (!rx_idle) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      tick(20);
      ps2c = 1'b0;
      tick(40);
      ps2c = 1'b1;
      tick(20);
    end
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  int d0, t0, b0, f0;

  initial begin
    // Reset state
    tick(3);
    check("rst_idle", rx_idle, 1);
    check("rst_dout", dout, 8'h00);
    check("rst_par", parity_err, 0);
    check("rst_frm", frame_err, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_to", timeout_tick, 0);
    reset = 1'b0;
    rx_en = 1'b1;
    tick(20);

    // Clean 0x1C
    d0 = done_cnt;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    tick(10);
    check("c1_done_cnt", done_cnt - d0, 1);
    check("c1_dout", cap_dout, 8'h1C);
    check("c1_par", cap_par, 0);
    check("c1_frm", cap_frm, 0);
    check("c1_latency", done_lat, 2);
    check("c1_idle", rx_idle, 1);

    // 0x1C with wrong parity
    d0 = done_cnt;
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    tick(10);
    check("par_done_cnt", done_cnt - d0, 1);
    check("par_dout", cap_dout, 8'h1C);
    check("par_par", cap_par, 1);
    check("par_frm", cap_frm, 0);

    // 0xF0 with bad stop bit
    d0 = done_cnt;
    send_bits(mk(8'hF0, 1'b1, 1'b0), 11);
    tick(10);
    check("stp_done_cnt", done_cnt - d0, 1);
    check("stp_dout", cap_dout, 8'hF0);
    check("stp_par", cap_par, 0);
    check("stp_frm", cap_frm, 1);
    check("stp_dout_held", dout, 8'hF0);

    // Watchdog: start + 4 data bits then stall
    d0 = done_cnt;
    t0 = to_cnt;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 5);
    check("to_busy", rx_idle, 0);
    tick(200);
    check("to_cnt", to_cnt - t0, 1);
    check("to_latency", to_lat, 200);
    check("to_no_done", done_cnt - d0, 0);
    check("to_dout_kept", dout, 8'hF0);
    check("to_frm_kept", frame_err, 1);
    check("to_idle", rx_idle, 1);

    d0 = done_cnt;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    tick(10);
    check("rec_done_cnt", done_cnt - d0, 1);
    check("rec_dout", cap_dout, 8'h1C);
    check("rec_par", cap_par, 0);
    check("rec_frm", cap_frm, 0);

    // Glitches of FILTER_LEN-1 cycles while idle
    b0 = busy_cnt;
    f0 = fall_cnt;
    for (int k = 0; k < 4; k++) begin
      ps2c = 1'b0;
      tick(7);
      ps2c = 1'b1;
      tick(20);
    end
    check("gl_busy", busy_cnt - b0, 0);
    check("gl_falls", fall_cnt - f0, 0);
    check("gl_idle", rx_idle, 1);

    // Full frame with rx_en low
    rx_en = 1'b0;
    d0 = done_cnt;
    b0 = busy_cnt;
    send_bits(mk(8'h55, 1'b1, 1'b1), 11);
    tick(10);
    check("en0_done", done_cnt - d0, 0);
    check("en0_busy", busy_cnt - b0, 0);
    check("en0_dout", dout, 8'h1C);

    // Reset after 6 bits of a frame
    rx_en = 1'b1;
    d0 = done_cnt;
    t0 = to_cnt;
    send_bits(mk(8'hFF, 1'b1, 1'b1), 6);
    check("mr_busy", rx_idle, 0);
    reset = 1'b1;
    tick(1);
    check("mr_idle", rx_idle, 1);
    check("mr_dout", dout, 8'h00);
    check("mr_par", parity_err, 0);
    check("mr_frm", frame_err, 0);
    reset = 1'b0;
    tick(250);
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_no_to", to_cnt - t0, 0);

    // Clean 0xA5 after reset
    d0 = done_cnt;
    send_bits(mk(8'hA5, 1'b1, 1'b1), 11);
    tick(10);
    check("a5_done_cnt", done_cnt - d0, 1);
    check("a5_dout", dout, 8'hA5);
    check("a5_par", parity_err, 0);
    check("a5_frm", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
